// File: rtl/regfile_access_arbiter.sv
// Two-client round-robin arbiter for a single-port-write / single-port-read register file.
// Each granted request issues to the register file for one cycle, then waits for its response to be consumed.
module regfile_access_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        req_valid,
    input  logic [1:0]        req_write,
    input  logic [ADDR_W-1:0] req_addr0,
    input  logic [ADDR_W-1:0] req_addr1,
    input  logic [DATA_W-1:0] req_wdata0,
    input  logic [DATA_W-1:0] req_wdata1,
    output logic [1:0]        req_ready,
    output logic [1:0]        rsp_valid,
    input  logic [1:0]        rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rf_mode,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [ADDR_W-1:0] rf_raddr,
    input  logic [DATA_W-1:0] rf_rdata
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              ptr_q, ptr_d;
    logic              id_q, id_d;
    logic              op_q, op_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [ADDR_W-1:0] raddr_q, raddr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [1:0]        grant;
    logic              gid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 1'b0;
            id_q    <= 1'b0;
            op_q    <= 1'b0;
            waddr_q <= '0;
            raddr_q <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            op_q    <= op_d;
            waddr_q <= waddr_d;
            raddr_q <= raddr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        op_d    = op_q;
        waddr_d = waddr_q;
        raddr_d = raddr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        grant   = 2'b00;
        gid     = 1'b0;

        case (state_q)
            IDLE: begin
                // Grant is gated by rst_n so req_ready reads 0 while reset is held.
                if (rst_n) begin
                    if (req_valid == 2'b11) begin
                        grant = ptr_q ? 2'b10 : 2'b01;
                    end else begin
                        grant = req_valid;
                    end
                end
                if (grant != 2'b00) begin
                    gid     = grant[1];
                    id_d    = gid;
                    op_d    = req_write[gid];
                    ptr_d   = ~ptr_q;
                    state_d = ISSUE;
                    // The rf address/data registers double as the transaction latch.
                    if (req_write[gid]) begin
                        waddr_d = gid ? req_addr1 : req_addr0;
                        wdata_d = gid ? req_wdata1 : req_wdata0;
                    end else begin
                        raddr_d = gid ? req_addr1 : req_addr0;
                    end
                end
            end
            ISSUE: begin
                rdata_d = op_q ? '0 : rf_rdata;
                state_d = RESP;
            end
            RESP: begin
                if (rsp_ready[id_q]) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign req_ready = grant;
    assign rsp_valid = (state_q == RESP) ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_rdata = rdata_q;
    assign rf_mode   = (state_q == ISSUE) && op_q;
    assign rf_waddr  = waddr_q;
    assign rf_wdata  = wdata_q;
    assign rf_raddr  = raddr_q;

endmodule

// File: doc/regfile_access_arbiter.md
Name: regfile_access_arbiter

Overview:
- Shares one single-write/single-read 32x32 register file between two requesters (client 0 and client 1).
- Accepts read or write requests through valid/ready handshakes and grants them round-robin.
- Drives the register file's mode/address/data lines for exactly one issue cycle per transaction.
- Returns the read data, or a write acknowledge, through a per-requester response handshake.

Parameters:
- ADDR_W, 5, register address width (32 entries).
- DATA_W, 32, register data width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  2  bit i: client i has a request pending.
- req_write  input  2  bit i: 1 = write, 0 = read.
- req_addr0 / req_addr1  input  ADDR_W  target register per client.
- req_wdata0 / req_wdata1  input  DATA_W  write value per client.
- req_ready  output  2  bit i: client i's request is accepted this cycle.
- rsp_valid  output  2  bit i: response available for client i.
- rsp_ready  input  2  bit i: client i consumes its response.
- rsp_rdata  output  DATA_W  read data (0 for write acknowledges).
- rf_mode  output  1  register file mode; 0 = read, 1 = write.
- rf_waddr  output  ADDR_W  register file write address.
- rf_wdata  output  DATA_W  register file write value.
- rf_raddr  output  ADDR_W  register file read address.
- rf_rdata  input  DATA_W  register file read value (combinational from rf_raddr).

Behaviour:
- Reset values (asynchronous on rst_n low, regardless of state):
  - outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rf_mode=0, rf_waddr=0, rf_wdata=0, rf_raddr=0.
  - internal: state=IDLE, priority pointer=0.
- A reset asserted mid-transaction aborts it. No write is issued after reset and no response is given.
- FSM states:
  - IDLE: req_ready is combinational and one-hot or zero. If one client is valid, it is granted. If both are valid, the client selected by the priority pointer is granted.
  - Acceptance: req_valid[i] & req_ready[i]. On acceptance, latch client id, op, addr and wdata, toggle the pointer to the other client, and go to ISSUE.
  - ISSUE: exactly one cycle.
    - Write: rf_mode=1, rf_waddr/rf_wdata = latched values.
    - Read: rf_mode=0, rf_raddr = latched addr, and rf_rdata is captured into rsp_rdata at the end of the cycle.
    - Write leaves rsp_rdata = 0. Next state is RESP.
  - RESP: rsp_valid[id]=1, the other bit is 0. rsp_rdata is held stable. When rsp_ready[id]=1, go to IDLE (response consumed that cycle). Otherwise stay in RESP with all values held.
- rf_mode is 1 only during ISSUE of a write; 0 in all other states. rf_waddr, rf_wdata and rf_raddr hold their last driven values outside ISSUE.
- req_ready is 0 in ISSUE and RESP. New requests are not accepted until IDLE.
- Minimum latency: accept at cycle N, ISSUE at N+1, rsp_valid at N+2. Peak throughput is one transaction per 3 cycles.
- Pointer rule:
  - Fairness: with both clients continuously valid, grants strictly alternate 0,1,0,1...
  - A single valid client is granted regardless of the pointer, and the pointer still toggles.
- Address range: all 2^ADDR_W addresses are legal. There is no hazard logic; ordering is strictly the grant order. A read granted after a write to the same address returns the new value.
- Request inputs are sampled only in IDLE. Changes to non-granted client inputs have no effect.

Test Plan:
- Reset: hold rst_n=0 with random inputs, then release. All outputs are 0 and the first simultaneous request grants client 0.
- Single write/read:
  - Client 0 writes 0xDEADBEEF to addr 5 (accept N): rf_mode=1, rf_waddr=5 at N+1; rsp_valid=2'b01, rsp_rdata=0 at N+2.
  - Client 0 then reads addr 5: rsp_rdata=0xDEADBEEF two cycles after accept.
- Contention: both clients valid every cycle, with reads of addr 3 (client 0) and addr 7 (client 1) and rsp_ready=2'b11. Grants alternate 0,1,0,1; rsp_valid alternates 01,10; each response arrives 3 cycles after the previous one.
- Backpressure: client 1 read with rsp_ready[1]=0 for 4 cycles. rsp_valid[1] and rsp_rdata are held for the full 4 cycles, req_ready=0 throughout, and IDLE is entered the cycle after rsp_ready[1]=1.
- Write-then-read ordering: client 1 writes 0x12345678 to addr 31 while client 0 has a pending read of addr 31, with the pointer favouring client 1. Client 0's response returns 0x12345678.
- Reset mid-op: deassert rst_n during ISSUE of a write. rf_mode drops to 0 immediately, no rsp_valid follows, and the pointer is back to 0.
